cordic_iter_ctrl: RTL and testbench

//  Iterative (one micro-rotation per clock) CORDIC engine controller. Accepts an (x,y,z) job over a

---
 rtl/cordic_pkg.sv | 20 ++
 rtl/cordic_stage.sv | 35 +++
 rtl/cordic_iter_ctrl.sv | 139 +++++++++++++
 tb/tb_cordic_iter_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC controller.
// Angles are signed fixed point with LSB = 2^-16 rad, the same scale as the arctan ROM.
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic signed [17:0] PI_2 = 18'sd102944;
  localparam logic signed [17:0] PI_4 = 18'sd51472;

  // 1.6468 in Q16; needs 17 bits since the gain exceeds 1.0.
  localparam logic [16:0] CORDIC_GAIN_Q16 = 17'd107922;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

endpackage

// File: rtl/cordic_stage.sv
// One combinational CORDIC micro-rotation: (x, y, z) -> (x', y', z') for a given shift and arctan.
// Zero latency; no flow control, the controller decides when the result is captured.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int XY_W    = 18,
  parameter int ANGLE_W = 18
) (
  input  logic signed [XY_W-1:0]    i_x,
  input  logic signed [XY_W-1:0]    i_y,
  input  logic signed [ANGLE_W-1:0] i_z,
  input  logic [3:0]                i_shift,
  input  logic [15:0]               i_atan,
  input  logic                      i_mode,
  output logic signed [XY_W-1:0]    o_x,
  output logic signed [XY_W-1:0]    o_y,
  output logic signed [ANGLE_W-1:0] o_z
);

  logic                      w_d;
  logic signed [XY_W-1:0]    w_x_sh;
  logic signed [XY_W-1:0]    w_y_sh;
  logic signed [ANGLE_W-1:0] w_atan;

  // Rotation steers z toward zero; vectoring steers y toward zero.
  assign w_d    = (i_mode == MODE_VEC) ? i_y[XY_W-1] : ~i_z[ANGLE_W-1];
  assign w_x_sh = i_x >>> i_shift;
  assign w_y_sh = i_y >>> i_shift;
  assign w_atan = $signed({{(ANGLE_W-16){1'b0}}, i_atan});

  assign o_x = w_d ? (i_x - w_y_sh) : (i_x + w_y_sh);
  assign o_y = w_d ? (i_y + w_x_sh) : (i_y - w_x_sh);
  assign o_z = w_d ? (i_z - w_atan) : (i_z + w_atan);

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC controller: one micro-rotation per clock, sequencing an external arctan ROM.
// out_valid rises ITERS+1 cycles after acceptance; result held until out_ready, no job overlap.
module cordic_iter_ctrl
  import cordic_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int GUARD   = 2,
  parameter int ANGLE_W = 18,
  parameter int ITERS   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_flush,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic                      i_in_mode,
  input  logic signed [DATA_W-1:0]  i_in_x,
  input  logic signed [DATA_W-1:0]  i_in_y,
  input  logic signed [ANGLE_W-1:0] i_in_z,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic signed [DATA_W-1:0]  o_out_x,
  output logic signed [DATA_W-1:0]  o_out_y,
  output logic signed [ANGLE_W-1:0] o_out_z,
  output logic [4:0]                o_rom_addr,
  input  logic [15:0]               i_rom_data,
  output logic                      o_busy
);

  localparam int XY_W = DATA_W + GUARD;
  localparam logic [3:0] LAST_ITER = 4'(ITERS - 1);
  localparam logic signed [XY_W-1:0] SAT_MAX = {{(GUARD+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [XY_W-1:0] SAT_MIN = {{(GUARD+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_e                    r_state;
  logic [3:0]                r_iter;
  logic                      r_mode;
  logic signed [XY_W-1:0]    r_x;
  logic signed [XY_W-1:0]    r_y;
  logic signed [ANGLE_W-1:0] r_z;

  logic signed [XY_W-1:0]    w_x_nx;
  logic signed [XY_W-1:0]    w_y_nx;
  logic signed [ANGLE_W-1:0] w_z_nx;

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [XY_W-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[DATA_W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    else                  return v[DATA_W-1:0];
  endfunction

  cordic_stage #(
    .XY_W    (XY_W),
    .ANGLE_W (ANGLE_W)
  ) u_stage (
    .i_x     (r_x),
    .i_y     (r_y),
    .i_z     (r_z),
    .i_shift (r_iter),
    .i_atan  (i_rom_data),
    .i_mode  (r_mode),
    .o_x     (w_x_nx),
    .o_y     (w_y_nx),
    .o_z     (w_z_nx)
  );

  // The counter parks at the last index in DONE, so bit 4 never sets.
  assign o_rom_addr = {1'b0, r_iter};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_iter      <= '0;
      r_mode      <= MODE_ROT;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      o_in_ready  <= 1'b1;
      o_out_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_out_x     <= '0;
      o_out_y     <= '0;
      o_out_z     <= '0;
    end else if (i_flush) begin
      // Output data deliberately untouched; only the job and its handshake are dropped.
      r_state     <= ST_IDLE;
      r_iter      <= '0;
      o_in_ready  <= 1'b1;
      o_out_valid <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_in_valid && o_in_ready) begin
            r_state    <= ST_RUN;
            r_iter     <= '0;
            r_mode     <= i_in_mode;
            r_x        <= {{GUARD{i_in_x[DATA_W-1]}}, i_in_x};
            r_y        <= {{GUARD{i_in_y[DATA_W-1]}}, i_in_y};
            r_z        <= i_in_z;
            o_in_ready <= 1'b0;
            o_busy     <= 1'b1;
          end
        end
        ST_RUN: begin
          r_x <= w_x_nx;
          r_y <= w_y_nx;
          r_z <= w_z_nx;
          if (r_iter == LAST_ITER) begin
            r_state <= ST_DONE;
            o_out_x <= sat(w_x_nx);
            o_out_y <= sat(w_y_nx);
            o_out_z <= w_z_nx;
          end else begin
            r_iter <= r_iter + 4'd1;
          end
        end
        ST_DONE: begin
          // Data settled on entry; valid follows one cycle later.
          if (!o_out_valid) begin
            o_out_valid <= 1'b1;
          end else if (i_out_ready) begin
            r_state     <= ST_IDLE;
            r_iter      <= '0;
            o_out_valid <= 1'b0;
            o_in_ready  <= 1'b1;
            o_busy      <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          o_in_ready <= 1'b1;
          o_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Bench for cordic_iter_ctrl: directed cases plus random jobs against an integer CORDIC model.
module tb_cordic_iter_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic in_mode = 1'b0;
  logic out_ready = 1'b1;
  logic signed [15:0] in_x = '0;
  logic signed [15:0] in_y = '0;
  logic signed [17:0] in_z = '0;
  logic in_ready, out_valid, busy;
  logic signed [15:0] out_x, out_y;
  logic signed [17:0] out_z;
  logic [4:0]  rom_addr;
  logic [15:0] rom_data;

  int checks = 0;
  int errors = 0;

  // floor(atan(2^-i) * 2^16)
  logic [15:0] atan_tab [16] = '{16'd51471, 16'd30385, 16'd16054, 16'd8149, 16'd4090, 16'd2047,
                                 16'd1023, 16'd511, 16'd255, 16'd127, 16'd63, 16'd31,
                                 16'd15, 16'd7, 16'd3, 16'd1};

  assign rom_data = (rom_addr < 5'd16) ? atan_tab[rom_addr[3:0]] : 16'd0;

  always #5 clk = ~clk;

  cordic_iter_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (flush),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_mode   (in_mode),
    .i_in_x      (in_x),
    .i_in_y      (in_y),
    .i_in_z      (in_z),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_x     (out_x),
    .o_out_y     (out_y),
    .o_out_z     (out_z),
    .o_rom_addr  (rom_addr),
    .i_rom_data  (rom_data),
    .o_busy      (busy)
  );

  longint ex, ey, ez;
  int lat;
  logic [4:0] addr_q [$];

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input longint obs, input longint exp, input longint tol);
    checks++;
    assert ((obs - exp) <= tol && (exp - obs) <= tol) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
    end
  endtask

  // Sixteen micro-rotations on unbounded integers, then saturate x/y and wrap z to 18 bits.
  function automatic void model(input logic mode, input int x0, input int y0, input int z0,
                                output longint xo, output longint yo, output longint zo);
    longint x = x0;
    longint y = y0;
    longint z = z0;
    longint xs, ys;
    logic dir;
    logic signed [17:0] zw;
    for (int i = 0; i < 16; i++) begin
      dir = mode ? (y < 0) : (z >= 0);
      xs = x >>> i;
      ys = y >>> i;
      if (dir) begin
        x = x - ys; y = y + xs; z = z - longint'(atan_tab[i]);
      end else begin
        x = x + ys; y = y - xs; z = z + longint'(atan_tab[i]);
      end
    end
    xo = (x > 32767) ? 32767 : ((x < -32768) ? -32768 : x);
    yo = (y > 32767) ? 32767 : ((y < -32768) ? -32768 : y);
    zw = z[17:0];
    zo = zw;
  endfunction

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic start_job(input logic mode, input int x, input int y, input int z);
    in_mode  = mode;
    in_x     = 16'(x);
    in_y     = 16'(y);
    in_z     = 18'(z);
    in_valid = 1'b1;
    model(mode, x, y, z, ex, ey, ez);
    @(negedge clk);
    in_valid = 1'b0;
    addr_q.delete();
    addr_q.push_back(rom_addr);
  endtask

  task automatic wait_valid(input string tag);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!out_valid) addr_q.push_back(rom_addr);
    end
    chk({tag, " latency"}, lat, 17);
  endtask

  task automatic chk_result(input string tag);
    chk({tag, " x"}, out_x, ex);
    chk({tag, " y"}, out_y, ey);
    chk({tag, " z"}, out_z, ez);
  endtask

  task automatic no_valid_for(input string tag, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk({tag, " spurious valid"}, seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    longint px, py, pz;
    longint hx, hy, hz;
    int mode_r, x_r, y_r, z_r;

    repeat (2) @(negedge clk);
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst out_x", out_x, 0);
    chk("rst out_y", out_y, 0);
    chk("rst out_z", out_z, 0);
    chk("rst rom_addr", rom_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    start_job(1'b0, 19898, 0, 0);
    chk("rot0 busy", busy, 1);
    chk("rot0 in_ready", in_ready, 0);
    wait_valid("rot0");
    chk_result("rot0");
    chk_near("rot0 ideal x", out_x, 32767, 16);
    chk_near("rot0 ideal y", out_y, 0, 16);
    chk_near("rot0 ideal z", out_z, 0, 16);
    @(negedge clk);
    chk("rot0 post out_valid", out_valid, 0);
    chk("rot0 post in_ready", in_ready, 1);
    chk("rot0 post busy", busy, 0);

    start_job(1'b0, 19898, 0, 51472);
    wait_valid("rot45");
    chk_result("rot45");
    chk_near("rot45 ideal x", out_x, 23170, 16);
    chk_near("rot45 ideal y", out_y, 23170, 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("rot45 rom_addr[%0d]", i), (addr_q.size() > i) ? addr_q[i] : 5'd31, i);
    end
    @(negedge clk);

    start_job(1'b1, 10000, 10000, 0);
    wait_valid("vec45");
    chk_result("vec45");
    chk_near("vec45 ideal z", out_z, 51472, 16);
    chk_near("vec45 ideal x", out_x, 23289, 16);
    chk_near("vec45 ideal y", out_y, 0, 16);
    @(negedge clk);

    start_job(1'b0, 32767, 32767, 0);
    wait_valid("sat");
    chk("sat x", out_x, 32767);
    chk("sat y", out_y, 32767);
    chk("sat z", out_z, ez);
    @(negedge clk);

    out_ready = 1'b0;
    start_job(1'b0, 12345, -2345, 30000);
    wait_valid("bp");
    repeat (10) @(negedge clk);
    chk_result("bp held");
    chk("bp out_valid", out_valid, 1);
    chk("bp in_ready", in_ready, 0);
    chk("bp busy", busy, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp release out_valid", out_valid, 0);
    chk("bp release in_ready", in_ready, 1);
    chk("bp release busy", busy, 0);

    px = ex; py = ey; pz = ez;
    start_job(1'b1, 5000, -7000, 0);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush run in_ready", in_ready, 1);
    chk("flush run busy", busy, 0);
    chk("flush run out_valid", out_valid, 0);
    chk("flush run keep x", out_x, px);
    chk("flush run keep y", out_y, py);
    chk("flush run keep z", out_z, pz);
    no_valid_for("flush run", 25);

    in_mode = 1'b0; in_x = 16'sd1000; in_y = 16'sd0; in_z = 18'sd0;
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
    chk("flush idle busy", busy, 0);
    chk("flush idle in_ready", in_ready, 1);
    no_valid_for("flush idle", 25);

    out_ready = 1'b0;
    start_job(1'b0, -15000, 8000, -40000);
    wait_valid("flush done");
    hx = ex; hy = ey; hz = ez;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b1;
    chk("flush done out_valid", out_valid, 0);
    chk("flush done in_ready", in_ready, 1);
    chk("flush done keep x", out_x, hx);
    chk("flush done keep y", out_y, hy);
    chk("flush done keep z", out_z, hz);

    for (int n = 0; n < 40; n++) begin
      mode_r = int'($urandom_range(1));
      x_r = int'($urandom_range(65534)) - 32767;
      y_r = int'($urandom_range(65534)) - 32767;
      if (mode_r == 0) z_r = int'($urandom_range(205888)) - 102944;
      else             z_r = int'($urandom_range(40000)) - 20000;
      start_job(mode_r[0], x_r, y_r, z_r);
      wait_valid($sformatf("rnd%0d", n));
      chk_result($sformatf("rnd%0d m%0d x%0d y%0d z%0d", n, mode_r, x_r, y_r, z_r));
      @(negedge clk);
    end

    start_job(1'b0, 19898, 0, 51472);
    repeat (7) @(negedge clk);
    chk("abort rom_addr", rom_addr, 7);
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", out_valid, 0);
    chk("abort in_ready", in_ready, 1);
    chk("abort busy", busy, 0);
    chk("abort out_x", out_x, 0);
    chk("abort out_y", out_y, 0);
    chk("abort out_z", out_z, 0);
    chk("abort rom_addr clr", rom_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    no_valid_for("abort", 25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
